// File: rtl/mem_access_unit_pkg.sv
// Shared types for the memory access unit.
//   mem_ctrl_t  : access kind requested by the core
//   mem_state_t : sequencing states of the access FSM
//   helpers     : store/read classification and natural-alignment test
package mem_access_unit_pkg;

  localparam int LANES = 4;  // byte lanes on the 32-bit data bus

  typedef enum logic [2:0] {
    NONE,
    READ_BYTE,
    READ_HALF,
    READ_WORD,
    STORE_BYTE,
    STORE_HALF,
    STORE_WORD
  } mem_ctrl_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RSP,
    FIN
  } mem_state_t;

  function automatic logic is_store(mem_ctrl_t c);
    is_store = (c == STORE_BYTE) || (c == STORE_HALF) || (c == STORE_WORD);
  endfunction

  function automatic logic is_read(mem_ctrl_t c);
    is_read = (c == READ_BYTE) || (c == READ_HALF) || (c == READ_WORD);
  endfunction

  // Byte accesses can never be misaligned.
  function automatic logic is_misaligned(mem_ctrl_t c, logic [1:0] off);
    logic m;
    m = 1'b0;
    case (c)
      READ_HALF, STORE_HALF: m = off[0];
      READ_WORD, STORE_WORD: m = |off;
      default:               m = 1'b0;
    endcase
    is_misaligned = m;
  endfunction

endpackage

// File: rtl/mem_access_unit_align.sv
// mem_align: combinational byte-lane steering.
//   ctrl, off      : access kind and byte offset within the word
//   load_unsigned  : zero- (1) or sign- (0) extend load results
//   store_data     : unaligned store operand in the low bits
//   rdata          : full bus read word
//   wstrb / wdata  : lane strobes and lane-shifted write data (0 for reads)
//   load_ext       : extracted and extended load value
module mem_align
  import mem_access_unit_pkg::*;
(
  input  mem_ctrl_t        ctrl,
  input  logic [1:0]       off,
  input  logic             load_unsigned,
  input  logic [31:0]      store_data,
  input  logic [31:0]      rdata,
  output logic [LANES-1:0] wstrb,
  output logic [31:0]      wdata,
  output logic [31:0]      load_ext
);

  logic [4:0]  sh;
  logic [31:0] rsh;
  logic        sgn;

  assign sh  = {off, 3'b000};
  assign rsh = rdata >> sh;

  always_comb begin
    wstrb    = '0;
    wdata    = '0;
    load_ext = '0;
    sgn      = 1'b0;
    case (ctrl)
      READ_BYTE: begin
        sgn      = rsh[7] & ~load_unsigned;
        load_ext = {{24{sgn}}, rsh[7:0]};
      end
      READ_HALF: begin
        sgn      = rsh[15] & ~load_unsigned;
        load_ext = {{16{sgn}}, rsh[15:0]};
      end
      READ_WORD: load_ext = rsh;
      STORE_BYTE: begin
        wstrb = 4'b0001 << off;
        wdata = {24'b0, store_data[7:0]} << sh;
      end
      STORE_HALF: begin
        wstrb = 4'b0011 << off;
        wdata = {16'b0, store_data[15:0]} << sh;
      end
      STORE_WORD: begin
        wstrb = 4'b1111;
        wdata = store_data;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: turns one core load/store into a single bus transaction.
//   clk, rst         : clock, synchronous active-high reset
//   start, mem_ctrl, load_unsigned, addr, store_data : request from core
//   busy, done, misaligned, load_data                : status / result
//   mem_req_*        : bus request channel (valid/ready handshake)
//   mem_rsp_*        : bus response (read data or write ack)
// Bus request fields are derived from the latched request only, so they stay
// stable for the whole time mem_req_valid is high.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  mem_ctrl_t         mem_ctrl,
  input  logic              load_unsigned,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       store_data,
  output logic              busy,
  output logic              done,
  output logic              misaligned,
  output logic [31:0]       load_data,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic              mem_req_we,
  output logic [LANES-1:0]  mem_req_wstrb,
  output logic [31:0]       mem_req_wdata,
  input  logic              mem_rsp_valid,
  input  logic [31:0]       mem_rsp_rdata
);

  mem_state_t        state;
  mem_ctrl_t         ctrl_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       sdata_q;
  logic              uns_q;
  logic              mis_q;
  logic [31:0]       load_ext;
  logic              start_mis;
  logic              start_bus;

  assign start_mis = is_misaligned(mem_ctrl, addr[1:0]);
  assign start_bus = (mem_ctrl != NONE) && !start_mis;

  mem_align u_align (
    .ctrl          (ctrl_q),
    .off           (addr_q[1:0]),
    .load_unsigned (uns_q),
    .store_data    (sdata_q),
    .rdata         (mem_rsp_rdata),
    .wstrb         (mem_req_wstrb),
    .wdata         (mem_req_wdata),
    .load_ext      (load_ext)
  );

  assign mem_req_addr = {addr_q[ADDR_W-1:2], 2'b00};
  assign mem_req_we   = is_store(ctrl_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      misaligned    <= 1'b0;
      mem_req_valid <= 1'b0;
      ctrl_q        <= NONE;
      addr_q        <= '0;
      sdata_q       <= '0;
      uns_q         <= 1'b0;
      mis_q         <= 1'b0;
      load_data     <= '0;
    end else begin
      done       <= 1'b0;
      misaligned <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (start_bus) begin
              ctrl_q        <= mem_ctrl;
              addr_q        <= addr;
              sdata_q       <= store_data;
              uns_q         <= load_unsigned;
              mis_q         <= 1'b0;
              mem_req_valid <= 1'b1;
              state         <= REQ;
            end else begin
              // NONE never reports misalignment
              mis_q <= (mem_ctrl != NONE) && start_mis;
              state <= FIN;
            end
          end
        end
        REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= RSP;
          end
        end
        RSP: begin
          if (mem_rsp_valid) begin
            if (is_read(ctrl_q)) load_data <= load_ext;
            done  <= 1'b1;
            state <= FIN;
          end
        end
        FIN: begin
          // Bus path enters FIN with done already high. The no-bus path
          // enters with done low and spends one extra cycle raising it.
          if (done) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            done       <= 1'b1;
            misaligned <= mis_q;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  logic        clk = 1'b0, rst = 1'b1, start = 1'b0, load_unsigned = 1'b0;
  logic        mem_req_ready = 1'b0, mem_rsp_valid = 1'b0;
  mem_ctrl_t   mem_ctrl = NONE;
  logic [31:0] addr = '0, store_data = '0, mem_rsp_rdata = '0;
  logic        busy, done, misaligned, mem_req_valid, mem_req_we;
  logic [31:0] load_data, mem_req_addr, mem_req_wdata;
  logic [3:0]  mem_req_wstrb;

  int          checks = 0, errors = 0;
  logic [31:0] model_load = '0;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .mem_ctrl(mem_ctrl),
    .load_unsigned(load_unsigned), .addr(addr), .store_data(store_data),
    .busy(busy), .done(done), .misaligned(misaligned), .load_data(load_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_we(mem_req_we),
    .mem_req_wstrb(mem_req_wstrb), .mem_req_wdata(mem_req_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata)
  );

  task automatic chk(input string tag, input string what, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s: got 0x%0h expected 0x%0h", tag, what, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk(tag, "busy", 32'(busy), 0);
    chk(tag, "done", 32'(done), 0);
    chk(tag, "misaligned", 32'(misaligned), 0);
    chk(tag, "req_valid", 32'(mem_req_valid), 0);
    chk(tag, "req_we", 32'(mem_req_we), 0);
    chk(tag, "req_wstrb", 32'(mem_req_wstrb), 0);
    chk(tag, "req_addr", mem_req_addr, 0);
    chk(tag, "req_wdata", mem_req_wdata, 0);
    chk(tag, "load_data", load_data, 0);
  endtask

  function automatic int size_of(mem_ctrl_t c);
    case (c)
      READ_BYTE, STORE_BYTE: return 1;
      READ_HALF, STORE_HALF: return 2;
      READ_WORD, STORE_WORD: return 4;
      default:               return 0;
    endcase
  endfunction

  // Drive one access starting at cycle 0 and observe it cycle by cycle.
  // rdly: cycles valid is held with ready low; sdly: cycles from entering
  // the response wait to the response. A stray response is injected before
  // the handshake whenever rdly > 0.
  task automatic run_txn(input string nm, input mem_ctrl_t ctl, input logic [31:0] a,
                         input logic [31:0] sd, input logic uns, input logic [31:0] rword,
                         input int rdly, input int sdly, input int e_done, input logic e_mis,
                         input logic e_bus, input logic [31:0] e_addr, input logic [3:0] e_strb,
                         input logic [31:0] e_wdata, input logic [31:0] e_load);
    int ndone, dcyc, nhs, hcyc, nvalid, fvalid;
    logic unstable, got_mis, busy1, busy_after, cap_we;
    logic [31:0] cap_addr, cap_wdata, got_load, lane_mask;
    logic [3:0] cap_strb;
    ndone = 0; dcyc = -1; nhs = 0; hcyc = -1; nvalid = 0; fvalid = -1;
    unstable = 0; got_mis = 1'bx; busy1 = 0; busy_after = 1; got_load = 'x;
    cap_addr = '0; cap_wdata = '0; cap_strb = '0; cap_we = 0;
    @(posedge clk); #1;
    start = 1; mem_ctrl = ctl; addr = a; store_data = sd; load_unsigned = uns;
    mem_req_ready = 0; mem_rsp_valid = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (c == 1) begin start = 0; busy1 = busy; end
      if (dcyc >= 0 && c == dcyc + 1) busy_after = busy;
      if (mem_req_valid) begin
        if (nvalid == 0) begin
          fvalid = c; cap_addr = mem_req_addr; cap_we = mem_req_we;
          cap_strb = mem_req_wstrb; cap_wdata = mem_req_wdata;
        end else if (mem_req_addr !== cap_addr || mem_req_we !== cap_we ||
                     mem_req_wstrb !== cap_strb || mem_req_wdata !== cap_wdata) begin
          unstable = 1;
        end
        nvalid++;
      end
      if (done) begin
        ndone++;
        if (dcyc < 0) begin dcyc = c; got_load = load_data; got_mis = misaligned; end
      end
      mem_req_ready = (c >= 1 + rdly);
      if (mem_req_valid && mem_req_ready) begin nhs++; hcyc = c; end
      mem_rsp_valid = (hcyc >= 0 && c == hcyc + 1 + sdly) || (c == 1 && rdly > 0);
      mem_rsp_rdata = (hcyc < 0) ? ~rword : rword;
      if (dcyc >= 0 && c >= dcyc + 2) break;
    end
    mem_req_ready = 0; mem_rsp_valid = 0;
    chk(nm, "done_cnt", ndone, 1);
    chk(nm, "done_cyc", dcyc, e_done);
    chk(nm, "misaligned", 32'(got_mis), 32'(e_mis));
    chk(nm, "load_data", got_load, e_load);
    chk(nm, "busy_c1", 32'(busy1), 1);
    chk(nm, "busy_after", 32'(busy_after), 0);
    if (e_bus) begin
      lane_mask = {{8{e_strb[3]}}, {8{e_strb[2]}}, {8{e_strb[1]}}, {8{e_strb[0]}}};
      chk(nm, "valid_cyc", fvalid, 1);
      chk(nm, "handshakes", nhs, 1);
      chk(nm, "stable", 32'(unstable), 0);
      chk(nm, "req_addr", cap_addr, e_addr);
      chk(nm, "req_we", 32'(cap_we), 32'(e_strb != 0));
      chk(nm, "req_wstrb", 32'(cap_strb), 32'(e_strb));
      chk(nm, "req_wdata", cap_wdata & lane_mask, e_wdata & lane_mask);
    end else begin
      chk(nm, "no_valid", nvalid, 0);
      chk(nm, "no_hs", nhs, 0);
    end
  endtask

  typedef struct {
    string       nm;
    mem_ctrl_t   ctl;
    logic [31:0] a, sd;
    logic        uns;
    logic [31:0] rword;
    int          rdly, sdly, e_done;
    logic        e_mis, e_bus;
    logic [31:0] e_addr;
    logic [3:0]  e_strb;
    logic [31:0] e_wdata, e_load;
  } vec_t;

  vec_t tab[10];

  initial begin
    tab[0] = '{"st_byte",   STORE_BYTE, 32'h1002, 32'h000000AB, 0, 32'h0,         0, 0, 3,  0, 1, 32'h1000, 4'b0100, 32'h00AB0000, 32'h0};
    tab[1] = '{"rd_half_s", READ_HALF,  32'h2002, 32'h0,        0, 32'h80011234,  0, 0, 3,  0, 1, 32'h2000, 4'b0000, 32'h0,        32'hFFFF8001};
    tab[2] = '{"rd_half_u", READ_HALF,  32'h2002, 32'h0,        1, 32'h80011234,  0, 0, 3,  0, 1, 32'h2000, 4'b0000, 32'h0,        32'h00008001};
    tab[3] = '{"rd_word_m", READ_WORD,  32'h3001, 32'h0,        0, 32'h0,         0, 0, 2,  1, 0, 32'h0,    4'b0000, 32'h0,        32'h00008001};
    tab[4] = '{"none",      NONE,       32'h4003, 32'h0,        0, 32'h0,         0, 0, 2,  0, 0, 32'h0,    4'b0000, 32'h0,        32'h00008001};
    tab[5] = '{"st_word_w", STORE_WORD, 32'h5000, 32'hDEADBEEF, 0, 32'h0,         5, 3, 11, 0, 1, 32'h5000, 4'b1111, 32'hDEADBEEF, 32'h00008001};
    tab[6] = '{"rd_byte3",  READ_BYTE,  32'h6003, 32'h0,        0, 32'h80FF0000,  2, 1, 6,  0, 1, 32'h6000, 4'b0000, 32'h0,        32'hFFFFFF80};
    tab[7] = '{"st_half_m", STORE_HALF, 32'h7001, 32'h1234BEEF, 0, 32'h0,         0, 0, 2,  1, 0, 32'h0,    4'b0000, 32'h0,        32'hFFFFFF80};
    tab[8] = '{"st_half2",  STORE_HALF, 32'h7002, 32'h1234BEEF, 0, 32'h0,         0, 0, 3,  0, 1, 32'h7000, 4'b1100, 32'hBEEF0000, 32'hFFFFFF80};
    tab[9] = '{"rd_half_m", READ_HALF,  32'h2001, 32'h0,        0, 32'h0,         0, 0, 2,  1, 0, 32'h0,    4'b0000, 32'h0,        32'hFFFFFF80};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_vals("reset");
    @(posedge clk); #1 rst = 0;

    // Directed table
    foreach (tab[i]) begin
      run_txn(tab[i].nm, tab[i].ctl, tab[i].a, tab[i].sd, tab[i].uns, tab[i].rword,
              tab[i].rdly, tab[i].sdly, tab[i].e_done, tab[i].e_mis, tab[i].e_bus,
              tab[i].e_addr, tab[i].e_strb, tab[i].e_wdata, tab[i].e_load);
      model_load = tab[i].e_load;
    end

    // Reset while waiting for the response, then a late response
    begin
      int nd, nv;
      nd = 0; nv = 0;
      @(posedge clk); #1;
      start = 1; mem_ctrl = READ_WORD; addr = 32'h8000; mem_req_ready = 1;
      @(negedge clk);                       // cycle 0
      @(negedge clk); start = 0;            // cycle 1: request handshakes
      chk("rst_rsp", "valid_c1", 32'(mem_req_valid), 1);
      @(negedge clk); rst = 1; mem_req_ready = 0;  // cycle 2: waiting for response
      @(negedge clk); rst = 0;              // cycle 3
      chk_reset_vals("rst_rsp");
      mem_rsp_valid = 1; mem_rsp_rdata = 32'h12345678;
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        mem_rsp_valid = 0;
        if (done) nd++;
        if (mem_req_valid) nv++;
      end
      chk("rst_rsp", "no_done", nd, 0);
      chk("rst_rsp", "no_valid", nv, 0);
      chk("rst_rsp", "load_data", load_data, 0);
      model_load = '0;
      run_txn("after_rst", READ_BYTE, 32'h9001, 32'h0, 1, 32'hAABBCCDD, 0, 0,
              3, 0, 1, 32'h9000, 4'b0000, 32'h0, 32'h000000CC);
      model_load = 32'h000000CC;
    end

    // Randomized accesses against an arithmetic model
    for (int i = 0; i < 40; i++) begin
      mem_ctrl_t   c;
      int          sz, off, rdl, sdl;
      logic [31:0] a, sd, rw, ea, ew, el;
      logic [3:0]  es;
      logic        u, mis, bus, st;
      longint      m, v;
      c   = mem_ctrl_t'($urandom_range(0, 6));
      a   = $urandom_range(0, 32'hFFFF);
      sd  = $urandom; rw = $urandom;
      u   = 1'($urandom_range(0, 1));
      rdl = $urandom_range(0, 4); sdl = $urandom_range(0, 4);
      sz  = size_of(c);
      off = int'(a % 4);
      st  = (c == STORE_BYTE) || (c == STORE_HALF) || (c == STORE_WORD);
      mis = (sz > 0) && ((a % sz) != 0);
      bus = (sz > 0) && !mis;
      ea  = a - off;
      m   = (64'd1 << (8 * sz)) - 1;
      es  = st ? 4'(((1 << sz) - 1) << off) : 4'b0000;
      ew  = 32'((longint'(sd) & m) << (8 * off));
      el  = model_load;
      if (bus && !st) begin
        v = (longint'(rw) >> (8 * off)) & m;
        if (!u && v[8 * sz - 1]) v = v | ~m;
        el = v[31:0];
      end
      run_txn($sformatf("rnd%0d", i), c, a, sd, u, rw, rdl, sdl,
              bus ? 3 + rdl + sdl : 2, mis, bus, ea, es, ew, el);
      model_load = el;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter ADDR_W, default 32, byte-address width of the memory bus.
REQ-002 Reset is synchronous and active-high; the unit has one clock. Ports: clk input 1, rising-edge clock; rst input 1, synchronous active-high reset.
REQ-003 start  input  1  single-cycle request strobe from the core; sampled only in IDLE.
REQ-004 mem_ctrl  input  mem_ctrl_t  access kind (NONE, READ_BYTE/HALF/WORD, STORE_BYTE/HALF/WORD).
REQ-005 load_unsigned  input  1  zero-extend load data when 1, sign-extend when 0.
REQ-006 addr  input  ADDR_W  effective byte address.
REQ-007 store_data  input  32  unaligned store operand in bits [7:0]/[15:0]/[31:0].
REQ-008 busy  output  1  high from the cycle after accepted start until done.
REQ-009 done  output  1  single-cycle completion pulse.
REQ-010 misaligned  output  1  valid with done; access was not naturally aligned.
REQ-011 load_data  output  32  extended load result; valid with done.
REQ-012 mem_req_valid  output  1  bus request valid.
REQ-013 mem_req_ready  input  1  bus accepts request.
REQ-014 mem_req_addr  output  ADDR_W  word-aligned address (bits [1:0] = 0).
REQ-015 mem_req_we  output  1  1 = write, 0 = read.
REQ-016 mem_req_wstrb  output  4  byte-lane write strobes; 0 on reads.
REQ-017 mem_req_wdata  output  32  lane-shifted write data.
REQ-018 mem_rsp_valid  input  1  response (read data or write ack) valid.
REQ-019 mem_rsp_rdata  input  32  full word of read data.

Function
REQ-020 FSM states: IDLE, REQ, RSP, FIN.
REQ-021 IDLE + start + mem_ctrl≠NONE + aligned: latch ctrl/addr/data/unsigned, go to REQ.
REQ-022 IDLE + start + (mem_ctrl=NONE or misaligned): go to FIN without bus traffic; misaligned=1 only when the address is misaligned.
REQ-023 Misaligned rule: HALF needs addr[0]=0, WORD needs addr[1:0]=0, BYTE is always aligned.
REQ-024 REQ: mem_req_valid=1 with stable addr/we/wstrb/wdata until mem_req_ready is sampled high, then go to RSP; valid drops the cycle after the handshake.
REQ-025 RSP: wait indefinitely for mem_rsp_valid; on it, register load_data (reads only) and go to FIN; a response arriving before the handshake is ignored.
REQ-026 FIN: done=1 for exactly one cycle, then go to IDLE; start is ignored in FIN.
REQ-027 Write strobes:
- BYTE: 4'b0001<<addr[1:0].
- HALF: 4'b0011<<addr[1:0].
- WORD: 4'b1111.
REQ-028 wdata: the operand is replicated/shifted left by 8*addr[1:0] into its lanes; non-strobed lanes are don't-care.
REQ-029 Read extraction: rdata>>(8*addr[1:0]), truncated to 8/16/32 bits, then zero- or sign-extended per load_unsigned.
REQ-030 Stores: load_data is held at its previous value.
REQ-031 Minimum latency for an aligned access with ready=1 and immediate response:
- start at cycle 0.
- mem_req_valid at cycle 1.
- mem_rsp_valid at cycle 2.
- done at cycle 3.

Reset
REQ-032 After rst, all of the following hold: state=IDLE; busy=0; done=0; misaligned=0; mem_req_valid=0; mem_req_we=0; mem_req_wstrb=0; mem_req_addr=0; mem_req_wdata=0; load_data=0.
REQ-033 rst asserted mid-transaction abandons it: no done pulse, mem_req_valid=0 the cycle after rst, and any later mem_rsp_valid is ignored in IDLE.

Structure
REQ-034 mem_state_t (IDLE/REQ/RSP/FIN) is added to the shared types package beside mem_ctrl_t; no new ctrl encodings are added.
REQ-035 Lane steering (strobe, wdata shift, rdata extract/extend) is one combinational sub-module, mem_align, instantiated once; the FSM and registers live in mem_access_unit.

Verification
REQ-036 STORE_BYTE, addr=0x1002, store_data=0x000000AB, ready=1 -> mem_req_addr=0x1000, we=1, wstrb=0100, wdata[23:16]=0xAB, done at cycle 3, misaligned=0.
REQ-037 READ_HALF, addr=0x2002, load_unsigned=0, rdata=0x8001_1234 -> load_data=0xFFFF8001; same with load_unsigned=1 -> 0x00008001.
REQ-038 READ_WORD, addr=0x3001 -> no mem_req_valid ever, done+misaligned=1 at cycle 2.
REQ-039 STORE_WORD, mem_req_ready low for 5 cycles and response 3 cycles after the handshake -> valid/addr/wdata stable throughout, exactly one handshake, one done pulse.
REQ-040 rst asserted in RSP, then mem_rsp_valid pulsed -> no done, all outputs at reset values, and the next start is serviced normally.
REQ-041 start with mem_ctrl=NONE -> done=1 and misaligned=0 at cycle 2, no bus activity.
